tft_console: RTL and testbench



---
 rtl/tft_console.sv | 176 +++++++++++++++++
 tb/tb_tft_console.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_console.sv
// Byte-stream console driving the TFT text memory write port.
// Define TFT_CONSOLE_TAB_EN to interpret 0x09 as an 8-column tab stop.
module tft_console #(
  parameter int          COLS           = 80,
  parameter int          ROWS           = 32,
  parameter int          ADDR_W         = 12,
  parameter logic [7:0]  BLANK_CHAR     = 8'h20,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR_ROW,
    CLEAR_ALL
  } state_e;

  localparam int                CW       = ADDR_W + 1;
  localparam logic [CW-1:0]     ROW_N    = CW'(COLS);
  localparam logic [CW-1:0]     ALL_N    = CW'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);

  state_e            state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic              accept;
  logic [ADDR_W-1:0] cur_addr;
  logic [4:0]        next_row;
  logic [ADDR_W-1:0] next_base;

  assign char_ready = reset_n && (state_q == IDLE);
  assign busy       = reset_n && (state_q != IDLE);
  assign accept     = char_valid && char_ready;
  assign cur_addr   = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);
  assign next_row   = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign next_base  = ADDR_W'(next_row) * COLS_A;

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  always_comb begin
    logic adv;
`ifdef TFT_CONSOLE_TAB_EN
    logic [7:0] tab_col;
    tab_col = {1'b0, col_q[6:3], 3'b000} + 8'd8;
`endif
    adv       = 1'b0;
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (char_data >= 8'h20 && char_data <= 8'h7E): begin
              wr_en_d   = 1'b1;
              wr_addr_d = cur_addr;
              wr_data_d = char_data;
              if (col_q == LAST_COL) begin
                // char write goes out first, row clear follows next cycle
                col_d   = 7'd0;
                row_d   = next_row;
                base_d  = next_base;
                cnt_d   = '0;
                state_d = CLEAR_ROW;
              end else begin
                col_d = col_q + 7'd1;
              end
            end
            (char_data == 8'h0D): col_d = 7'd0;
            (char_data == 8'h0A): adv = 1'b1;
            (char_data == 8'h08): begin
              if (col_q != 7'd0) begin
                col_d     = col_q - 7'd1;
                wr_en_d   = 1'b1;
                wr_addr_d = cur_addr - ADDR_W'(1);
                wr_data_d = BLANK_CHAR;
              end
            end
            (char_data == 8'h0C): begin
              col_d     = 7'd0;
              row_d     = 5'd0;
              wr_en_d   = 1'b1;
              wr_addr_d = '0;
              wr_data_d = BLANK_CHAR;
              base_d    = '0;
              cnt_d     = CW'(1);
              state_d   = CLEAR_ALL;
            end
`ifdef TFT_CONSOLE_TAB_EN
            (char_data == 8'h09): begin
              if (tab_col >= 8'(COLS)) adv = 1'b1;
              else col_d = tab_col[6:0];
            end
`endif
            default: ;
          endcase
        end
      end
      CLEAR_ROW, CLEAR_ALL: begin
        if (cnt_q == ((state_q == CLEAR_ROW) ? ROW_N : ALL_N)) begin
          state_d = IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + cnt_q[ADDR_W-1:0];
          wr_data_d = BLANK_CHAR;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // LF-style advance: first clear write issues on the accepting edge
    if (adv) begin
      col_d     = 7'd0;
      row_d     = next_row;
      wr_en_d   = 1'b1;
      wr_addr_d = next_base;
      wr_data_d = BLANK_CHAR;
      base_d    = next_base;
      cnt_d     = CW'(1);
      state_d   = CLEAR_ROW;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR_ALL : IDLE;
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_tft_console.sv
// Bench for tft_console: queue-based write-stream model plus directed vectors.
// Honors TFT_CONSOLE_TAB_EN the same way the design does.
module tb_tft_console;
  localparam int COLS = 80;
  localparam int ROWS = 32;
  localparam int AW   = 12;
`ifdef TFT_CONSOLE_TAB_EN
  localparam bit TAB_EN = 1'b1;
`else
  localparam bit TAB_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          char_valid = 1'b0;
  logic [7:0]    char_data = 8'h00;
  logic          char_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [6:0]    cursor_col;
  logic [4:0]    cursor_row;
  logic          busy;

  tft_console #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(AW),
    .BLANK_CHAR(8'h20), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          busy;
  } ent_t;

  ent_t q[$];
  ent_t cur = '0;
  int   mcol = 0;
  int   mrow = 0;
  bit   in_rst = 1'b0;
  bit   last_acc = 1'b0;

  task automatic push_clear(input int base, input int n);
    for (int i = 0; i < n; i++) q.push_back('{1'b1, AW'(base + i), 8'h20, 1'b1});
  endtask

  task automatic adv_row();
    mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
    push_clear(mrow * COLS, COLS);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      q.push_back('{1'b1, AW'(mrow * COLS + mcol), b, (mcol == COLS - 1)});
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        adv_row();
      end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      mcol = 0;
      adv_row();
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        q.push_back('{1'b1, AW'(mrow * COLS + mcol), 8'h20, 1'b0});
      end
    end else if (b == 8'h0C) begin
      mcol = 0;
      mrow = 0;
      push_clear(0, COLS * ROWS);
    end else if (TAB_EN && b == 8'h09) begin
      mcol = (mcol / 8 + 1) * 8;
      if (mcol >= COLS) begin
        mcol = 0;
        adv_row();
      end
    end
  endtask

  // Model advances on each edge; the cycle that follows is described by cur.
  always @(posedge clk) begin
    if (!reset_n) begin
      q.delete();
      mcol = 0;
      mrow = 0;
      cur = '{1'b0, '0, 8'h00, 1'b1};
      push_clear(0, COLS * ROWS);
      in_rst = 1'b1;
      last_acc = 1'b0;
    end else begin
      in_rst = 1'b0;
      last_acc = char_valid && !cur.busy;
      if (last_acc) model_byte(char_data);
      cur = (q.size() > 0) ? q.pop_front() : '0;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (!reset_n) begin
      if (char_ready || busy ||
          (in_rst && (wr_en || wr_addr != 0 || wr_data != 0 ||
                      cursor_col != 0 || cursor_row != 0))) begin
        errors++;
        $display("FAIL reset_out t=%0t: rdy=%0b busy=%0b en=%0b addr=%0d data=%h col=%0d row=%0d want all 0",
                 $time, char_ready, busy, wr_en, wr_addr, wr_data, cursor_col, cursor_row);
      end
    end else if (wr_en !== cur.en || busy !== cur.busy || char_ready !== !cur.busy ||
                 (cur.en && (wr_addr !== cur.addr || wr_data !== cur.data)) ||
                 int'(cursor_col) != mcol || int'(cursor_row) != mrow) begin
      errors++;
      $display("FAIL model t=%0t: got en=%0b addr=%0d data=%h busy=%0b rdy=%0b col=%0d row=%0d want en=%0b addr=%0d data=%h busy=%0b col=%0d row=%0d",
               $time, wr_en, wr_addr, wr_data, busy, char_ready, cursor_col, cursor_row,
               cur.en, cur.addr, cur.data, cur.busy, mcol, mrow);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    char_valid = 1'b1;
    char_data  = b;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!last_acc && n < 4000);
    char_valid = 1'b0;
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %h not accepted", b);
    end
  endtask

  task automatic drain(output int nw, output int first, output int last);
    int n = 0;
    nw = 0;
    first = -1;
    last = -1;
    forever begin
      @(negedge clk);
      n++;
      if (wr_en) begin
        if (nw == 0) first = int'(wr_addr);
        last = int'(wr_addr);
        nw++;
      end
      if (char_ready || n > 3000) break;
    end
    if (!char_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: char_ready got 0 want 1");
    end
  endtask

  int nw, f, l;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    drain(nw, f, l);
    chk("sweep_n", nw, 2560);
    chk("sweep_first", f, 0);
    chk("sweep_last", l, 2559);
    chk("sweep_col", cursor_col, 0);

    send(8'h41);
    @(negedge clk);
    chk("A_en", wr_en, 1);
    chk("A_addr", wr_addr, 0);
    chk("A_data", wr_data, 'h41);
    send(8'h42);
    @(negedge clk);
    chk("B_addr", wr_addr, 1);
    chk("B_data", wr_data, 'h42);
    chk("B_col", cursor_col, 2);

    send(8'h0D);
    repeat (3) send(8'h0A);
    chk("lf3_row", cursor_row, 3);
    repeat (79) send(8'h78);
    chk("pre_z_col", cursor_col, 79);
    send(8'h5A);
    drain(nw, f, l);
    chk("z_nw", nw, 81);
    chk("z_first", f, 319);
    chk("z_last", l, 399);
    chk("z_col", cursor_col, 0);
    chk("z_row", cursor_row, 4);

    repeat (27) send(8'h0A);
    drain(nw, f, l);
    chk("r31_row", cursor_row, 31);
    send(8'h0A);
    drain(nw, f, l);
    chk("lfwrap_nw", nw, 80);
    chk("lfwrap_first", f, 0);
    chk("lfwrap_last", l, 79);
    chk("lfwrap_row", cursor_row, 0);

    send(8'h08);
    drain(nw, f, l);
    chk("bs0_nw", nw, 0);
    chk("bs0_col", cursor_col, 0);

    send(8'h61); send(8'h62); send(8'h63);
    send(8'h08);
    drain(nw, f, l);
    chk("bs_nw", nw, 1);
    chk("bs_addr", f, 2);
    chk("bs_col", cursor_col, 2);

    send(8'h01); send(8'h7F); send(8'hFF);
    drain(nw, f, l);
    chk("other_nw", nw, 0);
    chk("other_col", cursor_col, 2);
    send(8'h0D);
    chk("cr_col", cursor_col, 0);

    repeat (3) send(8'h74);
    send(8'h09);
    drain(nw, f, l);
    chk("tab_nw", nw, 0);
    chk("tab_col", cursor_col, TAB_EN ? 8 : 3);
    repeat (TAB_EN ? 69 : 74) send(8'h75);
    chk("pretab_col", cursor_col, 77);
    send(8'h09);
    drain(nw, f, l);
    chk("tabwrap_nw", nw, TAB_EN ? 80 : 0);
    chk("tabwrap_first", f, TAB_EN ? 80 : -1);
    chk("tabwrap_last", l, TAB_EN ? 159 : -1);
    chk("tabwrap_col", cursor_col, TAB_EN ? 0 : 77);
    chk("tabwrap_row", cursor_row, TAB_EN ? 1 : 0);

    send(8'h71);
    send(8'h0C);
    repeat (99) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("ff_c100_addr", wr_addr, 99);
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    drain(nw, f, l);
    chk("resweep_n", nw, 2560);
    chk("resweep_first", f, 0);
    chk("resweep_last", l, 2559);
    send(8'h4B);
    @(negedge clk);
    chk("K_addr", wr_addr, 0);
    chk("K_data", wr_data, 'h4B);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
